// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents:
//   UART_MIN_TICKS   smallest legal oversampling ratio
//   uart_rx_state_t  one-hot receiver state; PARITY is always present in the
//                    encoding so that every build shares the same state type
//   maj3             three-input majority vote
package uart_pkg;

    localparam int UART_MIN_TICKS = 8;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_DONE   = 6'b100000
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser (two flops, reset to idle-high) plus falling-edge detect.
// Latency: 2 cycles pin-to-o_rx_s; o_fall is asserted in the first cycle o_rx_s is 0.
// Backpressure: none.
//
// Ports:
//   i_clk, reset  clock and synchronous active-high reset
//   i_rx          asynchronous serial line
//   o_rx_s        synchronised line level
//   o_fall        one-cycle pulse on a synchronised high-to-low transition
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic       r_s1;
    logic       r_s2;
    logic       r_prev;
    // Fills with ones after reset. Until r_prev holds a real line sample the
    // reset value of 1 would make a line that is already low look like an edge.
    logic [2:0] r_fill;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_fill <= '0;
        end else begin
            r_s1   <= i_rx;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_fill <= {r_fill[1:0], 1'b1};
        end
    end

    assign o_rx_s = r_s2;
    assign o_fall = r_fill[2] & r_prev & ~r_s2;

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: configurable data width, 1/2 stop bits, optional parity, 3-sample vote.
// Latency: o_valid at S + (NB-1)*TICKS_PER_BIT + MID + 2, S = first START cycle (pin + 3).
// Backpressure: none; o_valid is a one-cycle strobe and the consumer must take it.
//
// Build option: define UART_RX_PARITY_EN to expect a parity bit after the data bits.
//
// Ports:
//   i_clk, reset   clock and synchronous active-high reset
//   i_enable       permits a new frame to start (looked at only while idle)
//   i_rx           asynchronous serial line, idles high
//   o_rxdata       last received word, LSB first on the line, held between strobes
//   o_valid        one-cycle strobe qualifying o_rxdata and the error flags
//   o_busy         high whenever the receiver is not idle
//   o_frame_err    a stop bit was sampled low
//   o_parity_err   parity mismatch (constant 0 without UART_RX_PARITY_EN)
//   o_break        every bit after the start bit was sampled low
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 32,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 i_clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rxdata,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break
);

    localparam int CW  = $clog2(TICKS_PER_BIT);
    localparam int MID = (TICKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_SA   = CW'(MID - 1);
    localparam logic [CW-1:0] C_SB   = CW'(MID);
    localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
    localparam logic [3:0]    C_DLST = 4'(DATA_BITS - 1);
    localparam logic          C_SLST = 1'(STOP_BITS - 1);

    if (TICKS_PER_BIT < UART_MIN_TICKS) begin : g_bad_ticks
        $error("uart_rx_framed: TICKS_PER_BIT below UART_MIN_TICKS");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_rx_framed: PARITY_ODD must be 0 or 1");
    end

    uart_rx_state_t       r_state;
    uart_rx_state_t       w_next;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic                 r_stop_idx;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_any_one;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_rxdata;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_break;
    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_wrap;
    logic                 w_dec;
    logic                 w_vote;

    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .reset  (reset),
        .i_rx   (i_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    assign w_wrap = (r_cnt == C_LAST);
    assign w_dec  = (r_cnt == C_DEC);
    // Two earlier samples are registered; the third is the live synchronised
    // value, so the bit is decided in the same cycle as the last sample.
    assign w_vote = maj3(r_samp_a, r_samp_b, w_rx_s);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_enable && w_fall) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                // A start bit that votes high was only a glitch.
                if (w_dec && w_vote) begin
                    w_next = ST_IDLE;
                end else if (w_wrap) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_wrap && (r_idx == C_DLST)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (w_wrap) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at the last stop decision so the remainder of the stop
                // bit is spent idle and a back-to-back start edge is caught.
                if (w_dec && (r_stop_idx == C_SLST)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_par <= 1'b0;
            end else if (w_dec && (r_state == ST_DATA || r_state == ST_PARITY)) begin
                r_par <= r_par ^ w_vote;
            end
            if (w_next == ST_DONE) begin
                r_parity_err <= r_par ^ 1'(PARITY_ODD);
            end
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_samp_a    <= 1'b1;
            r_samp_b    <= 1'b1;
            r_shift     <= '0;
            r_any_one   <= 1'b0;
            r_ferr      <= 1'b0;
            r_rxdata    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
            r_busy      <= (w_next != ST_IDLE);

            if (r_state == ST_IDLE) begin
                r_cnt      <= '0;
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_any_one  <= 1'b0;
                r_ferr     <= 1'b0;
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                if (r_cnt == C_SA) begin
                    r_samp_a <= w_rx_s;
                end
                if (r_cnt == C_SB) begin
                    r_samp_b <= w_rx_s;
                end
                if (w_dec) begin
                    if (r_state == ST_DATA) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    // Any 1 after the start bit rules out a break.
                    if (r_state == ST_DATA || r_state == ST_PARITY || r_state == ST_STOP) begin
                        r_any_one <= r_any_one | w_vote;
                    end
                    if (r_state == ST_STOP && !w_vote) begin
                        r_ferr <= 1'b1;
                    end
                end
                if (w_wrap) begin
                    if (r_state == ST_DATA) begin
                        r_idx <= r_idx + 4'd1;
                    end
                    if (r_state == ST_STOP) begin
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
            end

            // The final stop vote is combinational here, so fold it in directly.
            if (w_next == ST_DONE) begin
                r_valid     <= 1'b1;
                r_rxdata    <= r_shift;
                r_frame_err <= r_ferr | ~w_vote;
                r_break     <= ~(r_any_one | w_vote);
            end
        end
    end

    assign o_rxdata    = r_rxdata;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;
    assign o_break     = r_break;

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised successor receiver for the serial command link. It converts an asynchronous UART line into parallel words of configurable width, with optional parity, one or two stop bits and 3-sample majority voting. It reports framing, parity and break conditions alongside each word. It sits between the board RX pin and the command decoder, in the same slot and on the same `i_clk` domain as the existing single-mode receiver.

## Interface
- `TICKS_PER_BIT`, 32: `i_clk` cycles per bit; legal range ≥ 8.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; used only when `UART_RX_PARITY_EN` is defined.
- `i_clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `i_enable`  input  1  allows a new frame to start; sampled only in IDLE.
- `i_rx`  input  1  asynchronous serial line; idles high.
- `o_rxdata`  output  DATA_BITS  last received word, LSB = first bit on the line; holds until the next `o_valid`.
- `o_valid`  output  1  one-cycle strobe; qualifies `o_rxdata` and all error flags.
- `o_busy`  output  1  high in every state except IDLE.
- `o_frame_err`  output  1  any stop bit sampled 0; meaningful with `o_valid`, 0 otherwise.
- `o_parity_err`  output  1  parity mismatch; meaningful with `o_valid`, 0 otherwise; tied 0 without the macro.
- `o_break`  output  1  all data, parity and stop bits sampled 0; meaningful with `o_valid`, 0 otherwise.

## Operation
- **Synchroniser.** `i_rx` passes through two flops, both reset to 1. A third flop holds the previous synchronised value. A falling edge is synchronised value 0 with previous value 1.
- **Bit timing.**
  - Counter `cnt` has width `$clog2(TICKS_PER_BIT)`. It is 0 on the first START cycle and counts 0…TICKS_PER_BIT-1, then wraps to 0.
  - MID = (TICKS_PER_BIT-1)/2.
  - The line is sampled at `cnt` = MID-1, MID and MID+1. The bit value is the majority of the three samples, decided at `cnt` = MID+1.
  - A bit index advances on each wrap.
- **States:** IDLE, START, DATA, PARITY (exists only with the macro), STOP, DONE.
- **IDLE:** go to START if `i_enable` is high and a falling edge is present; `cnt` and the bit index clear.
- **START:** at the decision point, a voted 1 is a glitch and returns to IDLE with no strobe; a voted 0 advances to DATA at the next wrap.
- **DATA:** DATA_BITS bits, shifted in LSB-first. After the last bit, advance to PARITY or STOP.
- **PARITY:** one bit. The error is set when XOR(data bits, parity bit) differs from PARITY_ODD.
- **STOP:** STOP_BITS bits; any voted 0 sets the frame error. At the decision point of the last stop bit, go to DONE without waiting for the wrap.
- **DONE:** one cycle.
  - `o_valid` = 1; `o_rxdata`, `o_frame_err`, `o_parity_err` and `o_break` present the frame.
  - Next state is IDLE.
  - The rest of the final stop bit is spent in IDLE, so a back-to-back start edge is accepted.
- **Break:** `o_break` = 1 implies `o_frame_err` = 1. The word (all zeros) is still delivered.
- **`i_enable` low mid-frame:** no effect; the frame completes.
- **Reset:**
  - All outputs go to 0; `o_rxdata` goes to 0.
  - State goes to IDLE and the synchroniser flops go to 1.
  - A frame in flight is discarded with no strobe.
  - A line already low when reset releases does not start a frame until a high-to-low transition is seen.

## Timing
- Pin-to-synchronised latency is 2 cycles; edge detect adds 1 cycle. Let S be the first START cycle.
- NB = 1 + DATA_BITS + P + STOP_BITS, where P = 1 with the macro and 0 without.
- `o_valid` is high exactly in cycle S + (NB-1)·TICKS_PER_BIT + MID + 2.
- `o_busy` is high from S through the `o_valid` cycle inclusive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state and the parity checker exist, and `PARITY_ODD` applies.
- **`UART_RX_PARITY_EN` undefined:**
  - No parity bit is expected and P = 0.
  - `o_parity_err` is constant 0.
  - The break check omits the parity bit.

## Structure
- Package `uart_pkg`: the `uart_rx_state_t` enum and a `UART_MIN_TICKS` = 8 constant. The enum is one-hot; PARITY is present in it regardless of the macro.
- Sub-module `uart_rx_sync`: the 2-flop synchroniser with reset-to-1 plus the falling-edge detector. Outputs are `o_rx_s` and `o_fall`.
- Elaboration-time assertions check the legal ranges of `TICKS_PER_BIT`, `DATA_BITS` and `STOP_BITS`.

## Test plan
All scenarios use TICKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated otherwise.
- **Basic frame, parity off:** send 0xA5, 8N1 → one `o_valid` with `o_rxdata` = 0xA5 and all flags 0, at S+9·16+7+2 = S+153.
- **Even parity:** with the macro, PARITY_ODD=0, send 0x3C with parity bit 0 → valid, no error. Repeat with parity bit 1 → `o_parity_err` = 1 and data 0x3C.
- **Glitch rejection:** a 4-cycle low pulse → no `o_valid` and return to IDLE. A single-cycle low spike at a data-bit centre of 0xFF → still 0xFF (majority vote).
- **Framing error and break:**
  - Stop bit 0 with data 0x55 → `o_frame_err` = 1, `o_break` = 0.
  - Line held low for 12 bits → `o_rxdata` = 0x00, `o_frame_err` = 1, `o_break` = 1.
- **Back-to-back frames:** STOP_BITS=2, DATA_BITS=7, two frames 0x41 then 0x7F with no idle gap → two strobes, both flags 0.
- **Reset and enable:**
  - Reset asserted in cycle 60 of a frame → outputs 0, no strobe, next frame 0x12 received correctly.
  - `i_enable`=0 during a start edge → no reception.
